// File: rtl/spi_cam_responder_pkg.sv
// Packet constants and pixel word type shared by the SPI camera responder files.
package spi_cam_responder_pkg;

    // Words sent ahead of the payload in every packet: ID word, then CRC word.
    localparam int unsigned HDR_WORDS = 2;
    localparam logic [15:0] CRC_WORD  = 16'h0000;
    localparam logic [3:0]  ID_NIBBLE = 4'h0;
    localparam int unsigned LINE_W    = 12;

    typedef logic [15:0] pix_word_t;

    // ID word carries the line number in its low 12 bits.
    function automatic pix_word_t id_word(input logic [LINE_W-1:0] line);
        return {ID_NIBBLE, line};
    endfunction

endpackage

// File: rtl/spi_cam_responder_if.sv
// SPI pins plus pixel stream handshake of the camera responder.
interface spi_cam_responder_if;
    import spi_cam_responder_pkg::*;

    logic      cs_i;
    logic      sclk_i;
    logic      miso_o;
    pix_word_t pix_data_i;
    logic      pix_valid_i;
    logic      pix_ready_o;
    logic      frame_done_o;
    logic      underrun_o;

    // Responder side.
    modport slave (
        input  cs_i, sclk_i, pix_data_i, pix_valid_i,
        output miso_o, pix_ready_o, frame_done_o, underrun_o
    );

    // SPI initiator / pixel source side.
    modport master (
        output cs_i, sclk_i, pix_data_i, pix_valid_i,
        input  miso_o, pix_ready_o, frame_done_o, underrun_o
    );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus a third flop for edge detection.
module sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Resetting to the idle level keeps reset release from looking like an edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_sync1 <= RESET_VAL;
            r_sync2 <= RESET_VAL;
            r_prev  <= RESET_VAL;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_level = r_sync2;
    assign o_rise  = r_sync2 & ~r_prev;
    assign o_fall  = ~r_sync2 & r_prev;

endmodule

// File: rtl/spi_cam_responder.sv
// SPI mode-3 responder streaming camera lines as packets: ID, CRC, then pixel payload.
module spi_cam_responder
    import spi_cam_responder_pkg::*;
#(
    parameter int unsigned PIXELS_PER_LINE = 80,
    parameter int unsigned LINES_PER_FRAME = 60
) (
    input logic                 clk_i,
    input logic                 reset_n_i,
    spi_cam_responder_if.slave  bus
);

    localparam int unsigned WORDS = HDR_WORDS + PIXELS_PER_LINE;
    localparam int unsigned WC_W  = $clog2(WORDS);

    localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(WORDS - 1);
    localparam logic [WC_W-1:0]   HDR_LAST  = WC_W'(HDR_WORDS - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES_PER_FRAME - 1);

    logic w_cs_level;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_sclk_fall;
    logic w_unused_sclk_level;
    logic w_unused_sclk_rise;

    logic              r_miso;
    logic              r_frame_done;
    logic              r_underrun;
    logic [LINE_W-1:0] r_line_cnt;
    logic [WC_W-1:0]   r_word_cnt;
    logic [3:0]        r_bit_cnt;
    pix_word_t         r_shift;

    logic              w_shift_edge;
    logic              w_word_end;
    logic              w_payload_load;
    logic              w_line_wrap;
    logic [LINE_W-1:0] w_next_line;

    sync_edge #(
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .i_async   (bus.cs_i),
        .o_level   (w_cs_level),
        .o_rise    (w_cs_rise),
        .o_fall    (w_cs_fall)
    );

    sync_edge #(
        .RESET_VAL (1'b1)
    ) u_sclk_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .i_async   (bus.sclk_i),
        .o_level   (w_unused_sclk_level),
        .o_rise    (w_unused_sclk_rise),
        .o_fall    (w_sclk_fall)
    );

    // Decode which kind of shift edge this cycle is; cs edges win over sclk edges.
    always_comb begin
        w_shift_edge   = w_sclk_fall && !w_cs_level && !w_cs_fall && !w_cs_rise;
        w_word_end     = w_shift_edge && (r_bit_cnt == 4'd15);
        w_payload_load = w_word_end && (r_word_cnt >= HDR_LAST) && (r_word_cnt != LAST_WORD);
        w_line_wrap    = (r_line_cnt == LAST_LINE);
        w_next_line    = w_line_wrap ? '0 : r_line_cnt + 1'b1;
    end

    // Packet sequencer: cs start/abort, bit shifting and next-word loading.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_miso       <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
            r_line_cnt   <= '0;
            r_word_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_cs_fall) begin
                r_word_cnt <= '0;
                r_bit_cnt  <= '0;
                r_shift    <= id_word(r_line_cnt);
            end else if (w_cs_rise) begin
                // Abort: line_cnt untouched so the same line is resent next time.
                r_word_cnt <= '0;
                r_bit_cnt  <= '0;
            end else if (w_shift_edge) begin
                r_miso <= r_shift[15];
                if (w_word_end) begin
                    r_bit_cnt <= '0;
                    if (r_word_cnt == LAST_WORD) begin
                        r_word_cnt   <= '0;
                        r_line_cnt   <= w_next_line;
                        r_shift      <= id_word(w_next_line);
                        r_frame_done <= w_line_wrap;
                    end else begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (r_word_cnt < HDR_LAST) begin
                            r_shift <= CRC_WORD;
                        end else if (bus.pix_valid_i) begin
                            r_shift <= bus.pix_data_i;
                        end else begin
                            r_shift    <= '0;
                            r_underrun <= 1'b1;
                        end
                    end
                end else begin
                    r_shift   <= r_shift << 1;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.miso_o       = r_miso;
    assign bus.pix_ready_o  = w_payload_load;
    assign bus.frame_done_o = r_frame_done;
    assign bus.underrun_o   = r_underrun;

endmodule

// File: tb/tb_spi_cam_responder.sv
// Directed bench: instance A uses the default 80-pixel line, instance B a 2-pixel line
// so that a full 60-line frame fits in a short run.
module tb_spi_cam_responder;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    spi_cam_responder_if bus_a ();
    spi_cam_responder_if bus_b ();

    spi_cam_responder u_dut_a (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus_a)
    );

    spi_cam_responder #(
        .PIXELS_PER_LINE (2),
        .LINES_PER_FRAME (60)
    ) u_dut_b (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus_b)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Pixel sources: word = 0x1000 + number of pixels already taken.
    int   pix_idx_a = 0;
    int   rdy_cnt_a = 0;
    int   pix_idx_b = 0;
    int   rdy_cnt_b = 0;
    int   fd_cnt_b  = 0;
    logic drop_en_a = 1'b0;
    int   drop_at_a = 0;

    assign bus_a.pix_valid_i = !(drop_en_a && (rdy_cnt_a == drop_at_a));
    assign bus_a.pix_data_i  = 16'h1000 + 16'(pix_idx_a);
    assign bus_b.pix_valid_i = 1'b1;
    assign bus_b.pix_data_i  = 16'h1000 + 16'(pix_idx_b);

    always @(posedge clk) begin
        if (bus_a.pix_ready_o) begin
            rdy_cnt_a <= rdy_cnt_a + 1;
            if (bus_a.pix_valid_i) pix_idx_a <= pix_idx_a + 1;
        end
        if (bus_b.pix_ready_o) begin
            rdy_cnt_b <= rdy_cnt_b + 1;
            pix_idx_b <= pix_idx_b + 1;
        end
        if (bus_b.frame_done_o) fd_cnt_b <= fd_cnt_b + 1;
    end

    task automatic set_sclk(input bit sel, input logic v);
        if (sel) bus_b.sclk_i = v;
        else     bus_a.sclk_i = v;
    endtask

    task automatic set_cs(input bit sel, input logic v);
        if (sel) bus_b.cs_i = v;
        else     bus_a.cs_i = v;
        repeat (6) @(negedge clk);
    endtask

    // Clock nbits out of the responder; sample just before each rising sclk edge.
    task automatic xfer(input bit sel, input int half, input int nbits,
                        output logic [15:0] w);
        w = '0;
        for (int i = 0; i < nbits; i++) begin
            set_sclk(sel, 1'b0);
            repeat (half) @(negedge clk);
            w = {w[14:0], (sel ? bus_b.miso_o : bus_a.miso_o)};
            set_sclk(sel, 1'b1);
            repeat (half) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus_a.cs_i = 1'b1; bus_a.sclk_i = 1'b1;
        bus_b.cs_i = 1'b1; bus_b.sclk_i = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus_a.miso_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_miso: got %b expected 0", bus_a.miso_o);
        end
        vectors++;
        if (bus_a.pix_ready_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_ready: got %b expected 0", bus_a.pix_ready_o);
        end
        vectors++;
        if (bus_a.frame_done_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_frame_done: got %b expected 0", bus_a.frame_done_o);
        end
        vectors++;
        if (bus_a.underrun_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_underrun: got %b expected 0", bus_a.underrun_o);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_header();
        logic [15:0] w;
        set_cs(0, 1'b0);
        xfer(0, 5, 16, w);
        vectors++;
        if (w !== 16'h0000) begin
            miscompares++; $display("FAIL header_id: got %h expected 0000", w);
        end
        xfer(0, 5, 16, w);
        vectors++;
        if (w !== 16'h0000) begin
            miscompares++; $display("FAIL header_crc: got %h expected 0000", w);
        end
    endtask

    // Continues the packet opened by test_header.
    task automatic test_packet();
        logic [15:0] w;
        for (int i = 0; i < 80; i++) begin
            xfer(0, 5, 16, w);
            vectors++;
            if (w !== 16'h1000 + 16'(i)) begin
                miscompares++;
                $display("FAIL payload[%0d]: got %h expected %h", i, w, 16'h1000 + 16'(i));
            end
        end
        vectors++;
        if (rdy_cnt_a !== 80) begin
            miscompares++; $display("FAIL ready_pulses: got %0d expected 80", rdy_cnt_a);
        end
        vectors++;
        if (bus_a.underrun_o !== 1'b0) begin
            miscompares++; $display("FAIL packet_underrun: got %b expected 0", bus_a.underrun_o);
        end
    endtask

    // Line 1 is already loaded; drop valid on payload word 5.
    task automatic test_underrun();
        logic [15:0] w;
        logic [15:0] exp;
        drop_at_a = rdy_cnt_a + 5;
        drop_en_a = 1'b1;
        xfer(0, 5, 16, w);
        vectors++;
        if (w !== 16'h0001) begin
            miscompares++; $display("FAIL line1_id: got %h expected 0001", w);
        end
        xfer(0, 5, 16, w);
        for (int k = 0; k < 7; k++) begin
            xfer(0, 5, 16, w);
            if (k == 5)     exp = 16'h0000;
            else if (k < 5) exp = 16'h1050 + 16'(k);
            else            exp = 16'h1050 + 16'(k - 1);
            vectors++;
            if (w !== exp) begin
                miscompares++; $display("FAIL underrun_word[%0d]: got %h expected %h", k, w, exp);
            end
        end
        vectors++;
        if (bus_a.underrun_o !== 1'b1) begin
            miscompares++; $display("FAIL underrun_set: got %b expected 1", bus_a.underrun_o);
        end
        set_cs(0, 1'b1);
        drop_en_a = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (bus_a.underrun_o !== 1'b1) begin
            miscompares++; $display("FAIL underrun_sticky: got %b expected 1", bus_a.underrun_o);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] w;
        set_cs(0, 1'b0);
        xfer(0, 5, 16, w);
        vectors++;
        if (w !== 16'h0001) begin
            miscompares++; $display("FAIL resend_id: got %h expected 0001", w);
        end
        bus_a.sclk_i = 1'b0;
        repeat (2) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        vectors++;
        if ({bus_a.miso_o, bus_a.pix_ready_o, bus_a.frame_done_o, bus_a.underrun_o} !== 4'b0000)
        begin
            miscompares++;
            $display("FAIL async_reset_outputs: got %b%b%b%b expected 0000", bus_a.miso_o,
                     bus_a.pix_ready_o, bus_a.frame_done_o, bus_a.underrun_o);
        end
        @(negedge clk);
        bus_a.sclk_i = 1'b1;
        bus_a.cs_i   = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        set_cs(0, 1'b0);
        xfer(0, 5, 16, w);
        vectors++;
        if (w !== 16'h0000) begin
            miscompares++; $display("FAIL post_reset_id: got %h expected 0000", w);
        end
        set_cs(0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        int          exp_fd;
        set_cs(1, 1'b0);
        for (int p = 0; p <= 60; p++) begin
            xfer(1, 4, 16, w);
            vectors++;
            if (w !== 16'(p % 60)) begin
                miscompares++; $display("FAIL b2b_id[%0d]: got %h expected %h", p, w, 16'(p % 60));
            end
            xfer(1, 4, 16, w);
            xfer(1, 4, 16, w);
            xfer(1, 4, 16, w);
            exp_fd = (p >= 59) ? 1 : 0;
            vectors++;
            if (fd_cnt_b !== exp_fd) begin
                miscompares++;
                $display("FAIL frame_done_after[%0d]: got %0d expected %0d", p, fd_cnt_b, exp_fd);
            end
        end
    endtask

    task automatic test_abort();
        logic [15:0] w;
        int          base_pix;
        int          base_rdy;
        set_cs(1, 1'b1);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        base_pix = pix_idx_b;
        base_rdy = rdy_cnt_b;
        set_cs(1, 1'b0);
        for (int i = 0; i < 12; i++) xfer(1, 4, 16, w);
        xfer(1, 4, 16, w);
        xfer(1, 4, 16, w);
        xfer(1, 4, 5, w);
        set_cs(1, 1'b1);
        set_cs(1, 1'b0);
        xfer(1, 4, 16, w);
        vectors++;
        if (w !== 16'h0003) begin
            miscompares++; $display("FAIL abort_id: got %h expected 0003", w);
        end
        xfer(1, 4, 16, w);
        vectors++;
        if (w !== 16'h0000) begin
            miscompares++; $display("FAIL abort_crc: got %h expected 0000", w);
        end
        xfer(1, 4, 16, w);
        vectors++;
        if (w !== 16'h1000 + 16'(base_pix + 7)) begin
            miscompares++;
            $display("FAIL abort_pix0: got %h expected %h", w, 16'h1000 + 16'(base_pix + 7));
        end
        xfer(1, 4, 16, w);
        vectors++;
        if (w !== 16'h1000 + 16'(base_pix + 8)) begin
            miscompares++;
            $display("FAIL abort_pix1: got %h expected %h", w, 16'h1000 + 16'(base_pix + 8));
        end
        vectors++;
        if (rdy_cnt_b - base_rdy !== 9) begin
            miscompares++;
            $display("FAIL abort_ready_pulses: got %0d expected 9", rdy_cnt_b - base_rdy);
        end
        set_cs(1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_header();
        test_packet();
        test_underrun();
        test_async_reset();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_cam_responder.md
SPI_CAM_RESPONDER -- requirements
Module: spi_cam_responder

Interface
REQ-001 SHALL have parameter PIXELS_PER_LINE, default 80, payload words per packet.
REQ-002 SHALL have parameter LINES_PER_FRAME, default 60, packets per frame.
REQ-003 SHALL have port clk_i, input, 1, single system clock.
REQ-004 SHALL have port reset_n_i, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port cs_i, input, 1, SPI chip select, active-low, asynchronous to clk_i.
REQ-006 SHALL have port sclk_i, input, 1, SPI clock, mode 3 (idle high), asynchronous to clk_i.
REQ-007 SHALL have port miso_o, output, 1, serial data to the SPI initiator, MSB first.
REQ-008 SHALL have port pix_data_i, input, 16, pixel word from the upstream source.
REQ-009 SHALL have port pix_valid_i, input, 1, pix_data_i valid.
REQ-010 SHALL have port pix_ready_o, output, 1; transfer occurs on a cycle with pix_valid_i and pix_ready_o both high.
REQ-011 SHALL have port frame_done_o, output, 1, one-cycle pulse when the last packet of a frame completes.
REQ-012 SHALL have port underrun_o, output, 1, sticky flag set by a payload load without pix_valid_i.

Function
REQ-013 SHALL pass cs_i and sclk_i each through a 2-flop synchronizer, then a third flop for edge detection.
REQ-014 SHALL support sclk_i high and low phases of at least 4 clk_i cycles; miso_o SHALL update within 4 clk_i cycles of a pin-level sclk_i falling edge.
REQ-015 Packet = ID word, CRC word, then PIXELS_PER_LINE payload words (82 words by default).
REQ-016 ID word SHALL be {4'h0, line_cnt[11:0]}; CRC word SHALL be 16'h0000.
REQ-017 On synchronized cs falling edge: word_cnt=0, bit_cnt=0, shift register loaded with the ID word of the current line_cnt.
REQ-018 On each synchronized sclk falling edge with cs low: miso_o <= shift[15]; shift <= shift<<1; bit_cnt++.
REQ-019 When the edge in REQ-018 drives bit 15 of a word (bit_cnt==15): shift <= next word, bit_cnt <= 0, word_cnt++ (this replaces the shift).
REQ-020 Next-word load for a payload word SHALL assert pix_ready_o for exactly that one cycle, regardless of pix_valid_i.
REQ-021 Payload load with pix_valid_i high SHALL load pix_data_i; with pix_valid_i low SHALL load 16'h0000 and set underrun_o.
REQ-022 After the last bit of the last payload word: word_cnt <= 0, line_cnt increments, and the next ID word is loaded so back-to-back packets stream without a cs deassertion.
REQ-023 line_cnt SHALL wrap from LINES_PER_FRAME-1 to 0; frame_done_o SHALL pulse on that wrap cycle.
REQ-024 cs rising edge mid-packet SHALL abort: bit_cnt, word_cnt cleared, line_cnt unchanged (the same line is resent), no pix_ready_o pulse.
REQ-025 sclk edges while cs is high SHALL be ignored; miso_o SHALL hold its last value.
REQ-026 cs falling and sclk falling edges in the same cycle: the cs load of REQ-017 takes priority and the sclk edge is dropped.
REQ-027 underrun_o SHALL clear only on reset.

Reset
REQ-028 reset_n_i low SHALL asynchronously force miso_o=0, pix_ready_o=0, frame_done_o=0, underrun_o=0, line_cnt=0, word_cnt=0, bit_cnt=0, shift=0.
REQ-029 Synchronizer flops SHALL reset to the idle level 1 (cs high, sclk high) so that reset release creates no false edge.

Structure
REQ-030 A shared package SHALL hold the packet constants (header word count 2, CRC value 16'h0000, ID nibble 4'h0) and the width typedef of the 16-bit pixel word.
REQ-031 A single sub-module, sync_edge (2-flop sync plus edge detect, reset value parameter), SHALL be instantiated once for cs_i and once for sclk_i.

Verification
REQ-032 Reset, cs low, 16 sclk cycles at 10 clk/period -> bits 0x0000 (ID, line 0); next 16 -> 0x0000 (CRC).
REQ-033 Pixel source 0x1000+n always valid, one full packet -> words 0x1000..0x104F, exactly 80 pix_ready_o pulses, underrun_o=0.
REQ-034 60 back-to-back packets with cs held low -> IDs 0x0000..0x003B, frame_done_o one pulse after packet 59, packet 61 ID 0x0000.
REQ-035 pix_valid_i low at payload word 5 -> word 5 reads 0x0000, underrun_o stays 1 until reset.
REQ-036 cs raised after 37 bits of line 3, then restarted -> first word is ID 0x0003, payload starts from the next unconsumed pixel.
REQ-037 reset_n_i pulsed low mid-word asynchronously -> all outputs 0 immediately; next packet ID 0x0000.
